// File: rtl/itype_sequencer.sv
// itype_sequencer
// Multicycle control FSM for the I-type path of the MIPS-subset core. It
// accepts one instruction at a time, decodes the opcode, selects the
// immediate extension mode, and sequences ALU, data-memory and register
// write-back. All outputs are decoded from the state register and the
// captured instruction; no input reaches an output combinationally.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready instruction handshake (ready only in IDLE)
//   instr             instruction word, sampled on the accept edge only
//   alu_zero          ALU zero flag, used in EXEC to resolve beq/bne
//   mem_ready         data-memory completion, sampled in MEM
//   ext_mode, imm     immediate extender control and captured imm field
//   alu_src_imm       ALU B operand select, alu_op ALU operation
//   mem_req, mem_we   data-memory request / store
//   reg_write         one-cycle rt write strobe, mem_to_reg selects memory
//   branch_taken      resolved branch, presented with done
//   done, err         completion pulse and status (00 ok/01 illegal/10 timeout)
//   retired_count     count of instructions completed without error
//
// state  | meaning
// IDLE   | ready for a new instruction
// DECODE | opcode decoded, extender driven; illegal opcodes exit to DONE
// EXEC   | ALU operation; branches resolve here
// MEM    | data-memory access, bounded by MEM_TIMEOUT cycles
// WB     | register write-back strobe
// DONE   | completion pulse with status
module itype_sequencer #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [1:0]       ext_mode,
  output logic [15:0]      imm,
  output logic             alu_src_imm,
  output logic [2:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             branch_taken,
  output logic             done,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] retired_count
);

  // The MEM cycle counter only needs to reach MEM_TIMEOUT-1: the last
  // cycle is recognised by compare, not by counting past it.
  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [5:0]       op_q;
  logic [15:0]      imm_q;
  logic [1:0]       err_q, err_nx;
  logic             taken_q, taken_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nx;

  // rs/rt fields are routed to the register file elsewhere.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:16];

  logic       dec_legal, dec_branch, dec_lw, dec_sw, dec_src;
  logic [1:0] dec_ext;
  logic [2:0] dec_alu;

  always_comb begin
    dec_legal  = 1'b1;
    dec_branch = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_src    = 1'b1;
    dec_ext    = 2'b01;
    dec_alu    = ALU_ADD;
    case (op_q)
      OP_ADDI, OP_ADDIU: dec_alu = ALU_ADD;
      OP_SLTI:           dec_alu = ALU_SLT;
      OP_ANDI: begin dec_ext = 2'b00; dec_alu = ALU_AND;  end
      OP_ORI:  begin dec_ext = 2'b00; dec_alu = ALU_OR;   end
      OP_LUI:  begin dec_ext = 2'b10; dec_alu = ALU_PASS; end
      OP_LW:             dec_lw = 1'b1;
      OP_SW:             dec_sw = 1'b1;
      OP_BEQ, OP_BNE: begin
        dec_branch = 1'b1;
        dec_src    = 1'b0;
        dec_alu    = ALU_SUB;
      end
      default: begin
        dec_legal = 1'b0;
        dec_src   = 1'b0;
        dec_ext   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    err_nx     = err_q;
    taken_nx   = taken_q;
    tmo_cnt_nx = '0;
    case (state)
      S_IDLE: begin
        err_nx   = 2'b00;
        taken_nx = 1'b0;
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_nx = S_EXEC;
        end else begin
          state_nx = S_DONE;
          err_nx   = 2'b01;
        end
      end
      S_EXEC: begin
        if (dec_branch) begin
          taken_nx = (op_q == OP_BEQ) ? alu_zero : !alu_zero;
          state_nx = S_DONE;
        end else if (dec_lw || dec_sw) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_nx = dec_lw ? S_WB : S_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_DONE;
          err_nx   = 2'b10;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
      end
      S_WB:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      imm_q         <= '0;
      err_q         <= '0;
      taken_q       <= 1'b0;
      tmo_cnt       <= '0;
      retired_count <= '0;
    end else begin
      err_q   <= err_nx;
      taken_q <= taken_nx;
      tmo_cnt <= tmo_cnt_nx;
      if (state == S_IDLE && instr_valid) begin
        op_q  <= instr[31:26];
        imm_q <= instr[15:0];
      end
      if (state == S_DONE && err_q == 2'b00)
        retired_count <= retired_count + CNT_W'(1);
    end
  end

  logic busy;
  assign busy         = (state != S_IDLE);
  assign instr_ready  = (state == S_IDLE);
  assign ext_mode     = busy ? dec_ext : 2'b00;
  assign imm          = busy ? imm_q : 16'h0000;
  assign alu_op       = busy ? dec_alu : 3'b000;
  assign alu_src_imm  = busy & dec_src;
  assign mem_req      = (state == S_MEM);
  assign mem_we       = (state == S_MEM) & dec_sw;
  assign reg_write    = (state == S_WB);
  assign mem_to_reg   = (state == S_WB) & dec_lw;
  assign done         = (state == S_DONE);
  assign branch_taken = (state == S_DONE) & taken_q;
  assign err          = (state == S_DONE) ? err_q : 2'b00;

endmodule

// File: tb/tb_itype_sequencer.sv
module tb_itype_sequencer;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [31:0]      instr = '0;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             instr_ready;
  logic [1:0]       ext_mode;
  logic [15:0]      imm;
  logic             alu_src_imm;
  logic [2:0]       alu_op;
  logic             mem_req, mem_we, reg_write, mem_to_reg;
  logic             branch_taken, done;
  logic [1:0]       err;
  logic [CNT_W-1:0] retired_count;

  itype_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready), .ext_mode(ext_mode),
    .imm(imm), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .mem_req(mem_req),
    .mem_we(mem_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .branch_taken(branch_taken), .done(done), .err(err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  err;
    logic        taken;
    int          mem_cyc;
    int          wb_cyc;
    logic        m2r;
    logic        we;
    logic [1:0]  ext;
    logic [2:0]  op;
    logic        src;
    logic [15:0] imm;
    int          lat;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: what one instruction should look like from the outside,
  // given the ALU flag and the MEM cycle on which memory answers (0 = never).
  function automatic exp_t model(input logic [31:0] ins, input logic z, input int ready_at);
    exp_t e;
    bit legal, br, lw, sw, ok;
    legal = 1; br = 0; lw = 0; sw = 0;
    e.err = 0; e.taken = 0; e.mem_cyc = 0; e.wb_cyc = 0; e.m2r = 0; e.we = 0;
    e.ext = 2'd1; e.op = 3'd0; e.src = 1; e.imm = ins[15:0]; e.lat = 0;
    case (ins[31:26])
      6'h08, 6'h09: e.op = 3'd0;
      6'h0A: e.op = 3'd4;
      6'h0C: begin e.ext = 2'd0; e.op = 3'd2; end
      6'h0D: begin e.ext = 2'd0; e.op = 3'd3; end
      6'h0F: begin e.ext = 2'd2; e.op = 3'd5; end
      6'h23: lw = 1;
      6'h2B: sw = 1;
      6'h04: begin br = 1; e.src = 0; e.op = 3'd1; e.taken = z;  end
      6'h05: begin br = 1; e.src = 0; e.op = 3'd1; e.taken = !z; end
      default: begin legal = 0; e.ext = 2'd0; e.src = 0; end
    endcase
    if (!legal) begin
      e.err = 2'd1;
      e.lat = 2;
    end else if (br) begin
      e.lat = 3;
    end else if (lw || sw) begin
      ok = (ready_at >= 1) && (ready_at <= MEM_TIMEOUT);
      e.mem_cyc = ok ? ready_at : MEM_TIMEOUT;
      e.err = ok ? 2'd0 : 2'd2;
      e.we = sw;
      if (lw && ok) begin e.wb_cyc = 1; e.m2r = 1; end
      e.lat = 3 + e.mem_cyc + ((lw && ok) ? 1 : 0);
    end else begin
      e.wb_cyc = 1;
      e.lat = 4;
    end
    return e;
  endfunction

  // Monitor / scoreboard
  bit busy = 0, ret_pend = 0;
  bit m2r_s, we_s, ctrl_bad;
  bit idle_bad = 0, inv_bad = 0;
  int lat, mcyc, wcyc;
  logic [CNT_W-1:0] exp_ret = '0;
  exp_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; ret_pend = 0; exp_ret = '0;
    end else begin
      if (ret_pend) begin
        chk("retired_count", retired_count, exp_ret);
        ret_pend = 0;
      end
      if (busy) begin
        lat++;
        if (mem_req) mcyc++;
        if (reg_write) wcyc++;
        if (mem_to_reg) m2r_s = 1;
        if (mem_we) we_s = 1;
        if ((mem_we && !mem_req) || (mem_to_reg && !reg_write) || instr_ready) inv_bad = 1;
        if (!done && (err != 2'd0 || branch_taken)) inv_bad = 1;
        if (q.size() > 0 && (ext_mode !== q[0].ext || imm !== q[0].imm ||
                             alu_op !== q[0].op || alu_src_imm !== q[0].src))
          ctrl_bad = 1;
        if (done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected actual=1 required=0");
          end else begin
            me = q.pop_front();
            chk("err", err, me.err);
            chk("branch_taken", branch_taken, me.taken);
            chk("mem_req_cycles", mcyc, me.mem_cyc);
            chk("reg_write_cycles", wcyc, me.wb_cyc);
            chk("mem_to_reg", m2r_s, me.m2r);
            chk("mem_we", we_s, me.we);
            chk("latency", lat, me.lat);
            chk("ctrl_hold", ctrl_bad, 0);
            exp_ret = exp_ret + CNT_W'((me.err == 2'd0) ? 1 : 0);
            ret_pend = 1;
          end
          busy = 0;
        end
      end else begin
        if (instr_ready !== 1'b1 || ext_mode != 0 || imm != 0 || alu_op != 0 ||
            alu_src_imm || mem_req || mem_we || reg_write || mem_to_reg ||
            branch_taken || done || err != 0)
          idle_bad = 1;
        if (instr_valid && instr_ready) begin
          busy = 1; lat = 0; mcyc = 0; wcyc = 0;
          m2r_s = 0; we_s = 0; ctrl_bad = 0;
        end
      end
    end
  end

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Called aligned to 1 time unit after a rising edge.
  task automatic issue(input logic [31:0] ins, input logic z, input int ready_at);
    int mc, n;
    logic [31:0] r;
    mc = 0; n = 0;
    while (instr_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    q.push_back(model(ins, z, ready_at));
    instr_valid = 1; instr = ins; alu_zero = z; mem_ready = 0;
    @(posedge clk); #1;
    r = $urandom();
    instr_valid = 0; instr = r;
    n = 0;
    while (instr_ready !== 1'b1 && n < 60) begin
      if (mem_req) begin mc++; mem_ready = (mc == ready_at); end
      else mem_ready = 0;
      instr_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    instr_valid = 0; mem_ready = 0;
    if (n >= 60) begin
      chk("completion_timeout", 1, 0);
      finish_run();
    end
  endtask

  logic [5:0] legal_ops [10] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05};

  initial begin
    int mc, n, bad;
    logic [31:0] r;
    logic [5:0] opc;

    #12;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_ctrl", {ext_mode, imm, alu_op, alu_src_imm}, 0);
    chk("rst_strobes", {mem_req, mem_we, reg_write, mem_to_reg, branch_taken, err}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    issue(32'h2008FFFF, 0, 0);   // addi
    issue(32'h3508FFFF, 0, 0);   // ori
    issue(32'h3C081234, 0, 0);   // lui
    issue(32'h8D090004, 0, 4);   // lw, memory answers on 4th MEM cycle
    issue(32'hAD090004, 0, 4);   // sw, 4th MEM cycle
    issue(32'hAD090004, 0, 0);   // sw, memory never answers
    issue(32'hAD090004, 0, 8);   // sw, answer on the last allowed cycle
    issue(32'h8D090004, 0, 9);   // lw, answer too late
    issue(32'h8D090004, 0, 1);   // lw, first MEM cycle
    issue(32'h1109FFFE, 1, 0);   // beq taken
    issue(32'h1509FFFE, 1, 0);   // bne not taken
    issue(32'h1109FFFE, 0, 0);   // beq not taken
    issue(32'hFC000000, 0, 0);   // illegal opcode 0x3F

    // Reset during MEM of a lw
    instr_valid = 1; instr = 32'h8D090004; mem_ready = 0;
    @(posedge clk); #1;
    instr_valid = 0;
    mc = 0; n = 0;
    while (mc < 3 && n < 20) begin
      @(posedge clk); #1; n++;
      if (mem_req) mc++;
    end
    chk("reset_reached_mem", mc, 3);
    rst_n = 0; q.delete();
    #1;
    chk("midrst_instr_ready", instr_ready, 1);
    chk("midrst_outputs", {ext_mode, imm, alu_op, alu_src_imm, mem_req, mem_we,
                           reg_write, mem_to_reg, branch_taken, done, err}, 0);
    chk("midrst_retired", retired_count, 0);
    @(posedge clk); #1; rst_n = 1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || reg_write || mem_req) bad = 1;
    end
    chk("post_reset_quiet", bad, 0);

    // Wrap: 2^CNT_W + 1 successful instructions from zero
    for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
      r = $urandom();
      issue({6'h08, r[25:0]}, 0, 0);
    end
    @(negedge clk);
    chk("retired_wrap", retired_count, 1);
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 2) opc = r[31:26];
      else opc = legal_ops[$urandom_range(0, 9)];
      issue({opc, r[25:0]}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("idle_outputs_zero", idle_bad, 0);
    chk("invariants", inv_bad, 0);
    finish_run();
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/itype_sequencer.md
Name: itype_sequencer

Overview:
- Multicycle control FSM for the I-type path of the MIPS-subset core.
- Accepts one instruction at a time and decodes the opcode.
- Selects the immediate extension mode (zero / sign / upper) for the 16-bit extender and sequences ALU, data-memory and register write-back.
- Sits between the fetch stage and the datapath; one instruction is in flight at a time.

Parameters:
- MEM_TIMEOUT, 8: maximum MEM-state cycles waiting for mem_ready before aborting (legal range ≥1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept
- instr  input  32  instruction word; opcode = [31:26], imm = [15:0]
- alu_zero  input  1  ALU zero flag, valid in EXEC
- mem_ready  input  1  data-memory completion
- ext_mode  output  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- imm  output  16  captured instr[15:0] to the extender
- alu_src_imm  output  1  ALU B operand = extended immediate
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 pass-B
- mem_req  output  1  data-memory request
- mem_we  output  1  store
- reg_write  output  1  write rt
- mem_to_reg  output  1  write-back source is memory
- branch_taken  output  1  branch resolved taken (DONE cycle)
- done  output  1  one-cycle completion pulse
- err  output  2  00 ok, 01 illegal opcode, 10 mem timeout (valid with done)
- retired_count  output  CNT_W  successfully completed instructions

Behaviour:
- Clock is clk; reset is asynchronous active-low, named rst_n.
- Reset behaviour:
  - State goes to IDLE.
  - All outputs are 0 except instr_ready = 1.
  - retired_count, the timeout counter and the captured instruction are cleared.
  - Reset mid-operation abandons the instruction: no done pulse, no write.
- All outputs are registered or decoded from state plus the captured instruction only (Moore). There is no input-to-output combinational path.
- States:
  - IDLE: instr_ready = 1. On instr_valid, capture instr and go to DECODE. instr_ready is 0 in every other state.
  - DECODE: drive ext_mode and imm from the captured instruction.
    - addi 001000, addiu 001001, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101 → ext_mode = 01.
    - andi 001100, ori 001101 → ext_mode = 00.
    - lui 001111 → ext_mode = 10.
    - Any other opcode → DONE with err = 01.
  - EXEC: alu_src_imm = 1, except beq/bne, which use 0 and alu_op = sub.
    - alu_op: addi/addiu/lw/sw = add, slti = slt, andi = and, ori = or, lui = pass-B.
    - beq: taken = alu_zero; bne: taken = !alu_zero. Latch taken, then go to DONE.
    - lw/sw → MEM. All others → WB.
  - MEM: mem_req = 1; mem_we = 1 for sw. The timeout counter increments each MEM cycle.
    - mem_ready sampled in any of the first MEM_TIMEOUT MEM cycles means success: lw → WB, sw → DONE.
    - mem_ready arriving in cycle MEM_TIMEOUT itself counts as success.
    - No mem_ready after MEM_TIMEOUT cycles → DONE with err = 10; lw performs no write-back.
  - WB: reg_write = 1 for exactly one cycle; mem_to_reg = 1 for lw. Then go to DONE.
  - DONE: done = 1 and err valid; branch_taken is the latched value (0 for non-branches). Then go to IDLE.
- ext_mode, imm, alu_op and alu_src_imm hold their values from DECODE through DONE. They return to 0 in IDLE.
- retired_count increments in DONE only when err = 00. It wraps modulo 2^CNT_W.
- Latency, with acceptance at edge T0 (IDLE cycle):
  - ALU ops: DECODE T1, EXEC T2, WB T3, DONE T4, instr_ready = 1 in T5.
  - Branches: DONE in T3.
  - lw with mem_ready on its first MEM cycle: MEM T3, WB T4, DONE T5.
  - sw with mem_ready on its first MEM cycle: MEM T3, DONE T4.
- instr_valid is ignored outside IDLE. The instr bus is sampled only on the accept edge.

Test Plan:
- addi 0x2008FFFF accepted at T0 → ext_mode = 01, imm = 0xFFFF from T1; alu_op = 000 and alu_src_imm = 1 at T2; reg_write = 1 only at T3; done = 1, err = 00 at T4; retired_count 0 → 1.
- ori 0x3508FFFF → ext_mode = 00, alu_op = 011. lui 0x3C081234 → ext_mode = 10, alu_op = 101. Both complete with reg_write pulse and err = 00.
- lw 0x8D090004 with mem_ready low for 3 MEM cycles, high on the 4th → mem_req high for 4 cycles, mem_we = 0, then WB with mem_to_reg = 1, then done with err = 00. Repeat as sw 0xAD090004 → mem_we = 1, no reg_write, done with err = 00.
- sw with mem_ready never asserted, MEM_TIMEOUT = 8 → mem_req high exactly 8 cycles, done with err = 10, retired_count unchanged. Repeat with mem_ready in cycle 8 → err = 00.
- beq with alu_zero = 1 → branch_taken = 1 with done at T3. bne with alu_zero = 1 → branch_taken = 0. Opcode 0x3F → done at T2 with err = 01, no reg_write or mem_req.
- rst_n driven low during MEM of a lw → all outputs 0 except instr_ready = 1, no reg_write or done afterwards. Also run 2^CNT_W + 1 addi (CNT_W = 4) → retired_count = 1 (wrap).
